// File: rtl/fp_div_pkg.sv
// Shared definitions for the FDIV.S issue/complete controller: NaN constant,
// flag bit positions, controller states and the operand class record.
package fp_div_pkg;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASS,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
        logic sub;
    } fpclass_t;

    function automatic logic [31:0] signed_inf(input logic s);
        return {s, 8'hFF, 23'd0};
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return {s, 31'd0};
    endfunction

endpackage

// File: rtl/fp_class32.sv
// Single-precision operand classifier; the sign bit is irrelevant here, so only
// the magnitude field is taken.
module fp_class32
    import fp_div_pkg::*;
(
    input  logic [30:0] mag,
    output fpclass_t    cls
);

    logic [7:0]  exp_f;
    logic [22:0] frac_f;

    assign exp_f  = mag[30:23];
    assign frac_f = mag[22:0];

    always_comb begin
        cls.zero = (exp_f == 8'h00) && (frac_f == 23'd0);
        cls.sub  = (exp_f == 8'h00) && (frac_f != 23'd0);
        cls.inf  = (exp_f == 8'hFF) && (frac_f == 23'd0);
        cls.nan  = (exp_f == 8'hFF) && (frac_f != 23'd0);
        cls.snan = (exp_f == 8'hFF) && (frac_f != 23'd0) && !frac_f[22];
    end

endmodule

// File: rtl/fp_div_ctrl.sv
// FDIV.S issue/complete controller: resolves IEEE special cases, drives the divider,
// repairs OF/UF encodings and accrues fflags. FP_DIV_CTRL_FTZ_EN flushes subnormal inputs to zero.
module fp_div_ctrl
    import fp_div_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             div_start,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic [31:0]      div_y,
    input  logic [4:0]       div_flags,
    input  logic             div_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_clr,
    output logic             busy
);

    localparam int WD_W = $clog2(WAIT_MAX + 1);

`ifdef FP_DIV_CTRL_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      y_q, y_d;
    logic [4:0]       fl_q, fl_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [WD_W-1:0]  wd_q, wd_d, wd_inc;

    fpclass_t ca, cb;
    logic     sgn, a_zero, b_zero, a_fin_nz, b_fin_nz;
    logic     spec_hit;
    logic [31:0] spec_y;
    logic [4:0]  spec_fl;
    logic     out_hs;

    fp_class32 u_class_a (.mag(a_q[30:0]), .cls(ca));
    fp_class32 u_class_b (.mag(b_q[30:0]), .cls(cb));

    assign sgn      = a_q[31] ^ b_q[31];
    assign a_zero   = ca.zero | (FTZ & ca.sub);
    assign b_zero   = cb.zero | (FTZ & cb.sub);
    assign a_fin_nz = !a_zero && !ca.inf && !ca.nan;
    assign b_fin_nz = !b_zero && !cb.inf && !cb.nan;
    assign wd_inc   = wd_q + WD_W'(1);

    // Special-case resolution; rule order matters, the first match wins.
    always_comb begin
        spec_hit = 1'b1;
        spec_y   = QNAN;
        spec_fl  = 5'd0;
        if (ca.nan || cb.nan) begin
            spec_fl[FLAG_NV] = ca.snan | cb.snan;
        end else if ((a_zero && b_zero) || (ca.inf && cb.inf)) begin
            spec_fl[FLAG_NV] = 1'b1;
        end else if (a_fin_nz && b_zero) begin
            spec_y           = signed_inf(sgn);
            spec_fl[FLAG_DZ] = 1'b1;
        end else if (ca.inf) begin
            spec_y = signed_inf(sgn);
        end else if (cb.inf || (a_zero && b_fin_nz)) begin
            spec_y = signed_zero(sgn);
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        y_d     = y_q;
        fl_d    = fl_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    tag_d   = in_tag;
                    state_d = S_CLASS;
                end
            end
            S_CLASS: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (spec_hit) begin
                    y_d     = spec_y;
                    fl_d    = spec_fl;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (div_valid) begin
                    state_d = S_RESP;
                    if (div_flags[FLAG_OF]) begin
                        y_d  = signed_inf(sgn);
                        fl_d = 5'd0;
                        fl_d[FLAG_OF] = 1'b1;
                        fl_d[FLAG_NX] = 1'b1;
                    end else if (div_flags[FLAG_UF]) begin
                        y_d  = signed_zero(sgn);
                        fl_d = 5'd0;
                        fl_d[FLAG_UF] = 1'b1;
                        fl_d[FLAG_NX] = 1'b1;
                    end else begin
                        y_d  = div_y;
                        fl_d = div_flags;
                        fl_d[FLAG_DZ] = 1'b0;
                    end
                end else if (wd_inc == WD_W'(WAIT_MAX)) begin
                    y_d     = QNAN;
                    fl_d    = 5'd0;
                    fl_d[FLAG_NV] = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_RESP: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                // The abandoned op's response (or its timeout) is swallowed here.
                if (div_valid || (wd_inc == WD_W'(WAIT_MAX))) state_d = S_IDLE;
                else wd_d = wd_inc;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_hs = (state_q == S_RESP) && out_ready && !flush;

    always_comb begin
        fflags_d = fflags_q;
        if (out_hs && fflags_clr) fflags_d = fl_q;
        else if (out_hs)          fflags_d = fflags_q | fl_q;
        else if (fflags_clr)      fflags_d = 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            y_q      <= '0;
            fl_q     <= '0;
            fflags_q <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            y_q      <= y_d;
            fl_q     <= fl_d;
            fflags_q <= fflags_d;
            wd_q     <= wd_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign div_start = (state_q == S_ISSUE);
    assign out_valid = (state_q == S_RESP);
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign out_y     = y_q;
    assign out_flags = fl_q;
    assign out_tag   = tag_q;
    assign fflags    = fflags_q;

endmodule

// File: tb/tb_fp_div_ctrl.sv
// Directed bench for fp_div_ctrl with a one-cycle-latency divider stand-in.
module tb_fp_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        div_start;
    logic [31:0] div_a, div_b, div_y;
    logic [4:0]  div_flags;
    logic        div_valid;
    logic        out_valid, out_ready;
    logic [31:0] out_y;
    logic [4:0]  out_flags, out_tag, fflags;
    logic        fflags_clr, busy;

    logic dv_en   = 1'b1;
    logic mdl_vld = 1'b0;
    logic man_vld = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    fp_div_ctrl #(.TAG_W(5), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .flush(flush),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_y(div_y), .div_flags(div_flags), .div_valid(div_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_flags(out_flags), .out_tag(out_tag),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Divider stand-in: answers one cycle after div_start when enabled.
    always @(posedge clk) mdl_vld <= dv_en & div_start;
    assign div_valid = mdl_vld | man_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          output int lat, output int slat, output int nst);
        lat = -1; slat = -1; nst = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (div_start) begin
                nst++;
                if (slat < 0) slat = k;
            end
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] sy [4];
    logic [4:0]  sf [4];

    initial begin
        int lat, slat, nst;
        logic [31:0] hy;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        flush = 1'b0; div_y = '0; div_flags = '0; out_ready = 1'b1; fflags_clr = 1'b0;

        sa[0] = 32'h00000000; sb[0] = 32'h00000000; sy[0] = 32'h7FC00000; sf[0] = 5'h10;
        sa[1] = 32'h7F800001; sb[1] = 32'h3F800000; sy[1] = 32'h7FC00000; sf[1] = 5'h10;
        sa[2] = 32'h7FC00001; sb[2] = 32'h3F800000; sy[2] = 32'h7FC00000; sf[2] = 5'h00;
        sa[3] = 32'hFF800000; sb[3] = 32'h40000000; sy[3] = 32'hFF800000; sf[3] = 5'h00;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_out_y",     out_y,              32'd0);
        check("rst_fflags",    {27'd0, fflags},    32'd0);

        // 6.0 / 2.0 through the divider
        div_y = 32'h40400000; div_flags = 5'h00;
        run_op(32'h40C00000, 32'h40000000, 5'd7, lat, slat, nst);
        check("div_lat",   lat,  4);
        check("div_slat",  slat, 2);
        check("div_nst",   nst,  1);
        check("div_y",     out_y, 32'h40400000);
        check("div_flags", {27'd0, out_flags}, 32'h00);
        check("div_tag",   {27'd0, out_tag},   32'd7);
        @(negedge clk);
        check("div_fflags", {27'd0, fflags}, 32'h00);

        // 1.0 / 0 -> +Inf, DZ
        run_op(32'h3F800000, 32'h00000000, 5'd3, lat, slat, nst);
        check("dz_lat",   lat, 2);
        check("dz_nst",   nst, 0);
        check("dz_y",     out_y, 32'h7F800000);
        check("dz_flags", {27'd0, out_flags}, 32'h08);
        @(negedge clk);
        check("dz_fflags", {27'd0, fflags}, 32'h08);
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        check("clr_fflags", {27'd0, fflags}, 32'h00);

        for (int i = 0; i < 4; i++) begin
            run_op(sa[i], sb[i], 5'(i), lat, slat, nst);
            check($sformatf("sp%0d_lat", i), lat, 2);
            check($sformatf("sp%0d_nst", i), nst, 0);
            check($sformatf("sp%0d_y", i), out_y, sy[i]);
            check($sformatf("sp%0d_flags", i), {27'd0, out_flags}, {27'd0, sf[i]});
            @(negedge clk);
        end
        check("sp_fflags", {27'd0, fflags}, 32'h10);
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;

        // divider overflow repaired to +Inf, OF|NX
        div_y = 32'h7FFFFFFF; div_flags = 5'h04;
        run_op(32'h7F000000, 32'h00800000, 5'd9, lat, slat, nst);
        check("of_lat",   lat, 4);
        check("of_y",     out_y, 32'h7F800000);
        check("of_flags", {27'd0, out_flags}, 32'h05);
        @(negedge clk);
        check("of_fflags", {27'd0, fflags}, 32'h05);

        // consumer stall; DZ from divider is masked
        div_y = 32'h40400000; div_flags = 5'h09;
        out_ready = 1'b0;
        run_op(32'h40C00000, 32'h40000000, 5'd12, lat, slat, nst);
        check("hold_lat",   lat, 4);
        check("hold_flags", {27'd0, out_flags}, 32'h01);
        hy = out_y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid",  {31'd0, out_valid}, 32'd1);
            check("hold_y",      out_y, hy);
            check("hold_tag",    {27'd0, out_tag}, 32'd12);
            check("hold_ready",  {31'd0, in_ready}, 32'd0);
            check("hold_fflags", {27'd0, fflags}, 32'h05);
        end
        out_ready = 1'b1; fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        @(negedge clk);
        check("hsclr_fflags", {27'd0, fflags}, 32'h01);
        check("hsclr_valid",  {31'd0, out_valid}, 32'd0);

        // flush while waiting, late response must vanish
        dv_en = 1'b0;
        div_y = 32'h12345678; div_flags = 5'h1F;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000; in_tag = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fl_start", {31'd0, div_start}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl_busy_drain", {31'd0, busy}, 32'd1);
        man_vld = 1'b1;
        @(negedge clk);
        man_vld = 1'b0;
        check("fl_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fl_no_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check("fl_fflags", {27'd0, fflags}, 32'h01);
        dv_en = 1'b1; div_y = 32'h40400000; div_flags = 5'h00;
        run_op(32'h40C00000, 32'h40000000, 5'd5, lat, slat, nst);
        check("afl_lat", lat, 4);
        check("afl_y",   out_y, 32'h40400000);
        check("afl_tag", {27'd0, out_tag}, 32'd5);
        @(negedge clk);

        // divider never answers -> watchdog
        dv_en = 1'b0;
        run_op(32'h40C00000, 32'h40000000, 5'd6, lat, slat, nst);
        check("wd_lat",   lat, 18);
        check("wd_y",     out_y, 32'h7FC00000);
        check("wd_flags", {27'd0, out_flags}, 32'h10);
        @(negedge clk);
        check("wd_fflags", {27'd0, fflags}, 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
